// File: rtl/board_dump_uart_pkg.sv
// Shared constants for the board dump reader: ASCII characters, piece codes
// and the top-level sequencing states.
package board_dump_uart_pkg;

    localparam logic [7:0] CHAR_EMPTY = 8'h2E;
    localparam logic [7:0] CHAR_P1    = 8'h58;
    localparam logic [7:0] CHAR_P2    = 8'h4F;
    localparam logic [7:0] CHAR_BAD   = 8'h3F;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_W     = 8'h57;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    localparam logic [1:0] PIECE_EMPTY = 2'b00;
    localparam logic [1:0] PIECE_P1    = 2'b01;
    localparam logic [1:0] PIECE_P2    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SETTLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    function automatic logic [7:0] piece_char(input logic [1:0] piece);
        case (piece)
            PIECE_EMPTY: return CHAR_EMPTY;
            PIECE_P1:    return CHAR_P1;
            PIECE_P2:    return CHAR_P2;
            default:     return CHAR_BAD;
        endcase
    endfunction

endpackage

// File: rtl/board_dump_uart_tx_byte.sv
// 8N1 byte serializer: accepts one byte on valid&&ready, shifts it out LSB
// first and pulses last during the final cycle of the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       last
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic             active;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       shift;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_MAX);
    assign ready   = !active;
    assign last    = active && bit_end && (bit_cnt == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else if (!active) begin
            if (valid) begin
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                tx       <= 1'b0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
            end else begin
                tx      <= shift[0];
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // A stop-bit one rides above the data so the ninth shift lands on it.
    always_ff @(posedge clk) begin
        if (!active && valid) begin
            shift <= {1'b1, data};
        end else if (active && bit_end && bit_cnt != 4'd9) begin
            shift <= {1'b1, shift[8:1]};
        end
    end

endmodule

// File: rtl/board_dump_uart.sv
// Scans the 8x8 board through the debug read port and streams it as ASCII
// rows (row 7 first) plus a winner trailer over an 8N1 UART.
module board_dump_uart #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] d_piece_data,
    input  logic [1:0] winner,
    output logic       e_debug,
    output logic       read_board,
    output logic [2:0] d_r_row,
    output logic [2:0] d_r_col,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    import board_dump_uart_pkg::*;

    state_t     state, state_next;
    logic [2:0] row;
    logic [3:0] pos;
    logic [1:0] trl_idx;
    logic       in_trailer;
    logic       final_char;
    logic       char_done;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [7:0] tx_data;

    assign final_char = in_trailer && (trl_idx == 2'd3);
    assign char_done  = (state == ST_SEND) && tx_last;
    assign busy       = (state != ST_IDLE);
    assign e_debug    = busy;
    assign read_board = busy;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ADDR;
            ST_ADDR:   state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_LOAD;
            ST_LOAD: begin
                tx_valid = 1'b1;
                if (tx_ready) state_next = ST_SEND;
            end
            ST_SEND:   if (tx_last) state_next = final_char ? ST_IDLE : ST_ADDR;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Only consumed in LOAD, where the read data has had two cycles to settle.
    always_comb begin
        tx_data = CHAR_LF;
        if (in_trailer) begin
            case (trl_idx)
                2'd0:    tx_data = CHAR_W;
                2'd1:    tx_data = CHAR_ZERO + {6'd0, winner};
                2'd2:    tx_data = CHAR_CR;
                default: tx_data = CHAR_LF;
            endcase
        end else if (pos < 4'd8) begin
            tx_data = piece_char(d_piece_data);
        end else if (pos == 4'd8) begin
            tx_data = CHAR_CR;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            row        <= 3'd7;
            pos        <= '0;
            trl_idx    <= '0;
            in_trailer <= 1'b0;
            d_r_row    <= '0;
            d_r_col    <= '0;
            done       <= 1'b0;
        end else begin
            done <= char_done && final_char;
            if (state == ST_IDLE && start) begin
                row        <= 3'd7;
                pos        <= '0;
                trl_idx    <= '0;
                in_trailer <= 1'b0;
            end
            if (state == ST_ADDR) begin
                d_r_row <= row;
                d_r_col <= pos[2:0];
            end
            if (char_done) begin
                if (in_trailer) begin
                    trl_idx <= trl_idx + 2'd1;
                end else if (pos == 4'd9) begin
                    pos <= '0;
                    if (row == 3'd0) in_trailer <= 1'b1;
                    else             row        <= row - 3'd1;
                end else begin
                    pos <= pos + 4'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk_25MHz),
        .rst_n (rst_n),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .tx    (uart_tx),
        .last  (tx_last)
    );

endmodule
